// File: rtl/tdc_core_param.sv
// TDC back-end: captures the sampled ring-oscillator phases and ripple count
// once per reference clock, decodes a {coarse, fine} timestamp and emits
// either the raw timestamp or the (optionally accumulated) period difference.
module tdc_core_param #(
    parameter int N_PH    = 16,
    parameter int CNT_W   = 7,
    parameter int AVG_LOG = 0,
    localparam int FW     = $clog2(2 * N_PH),
    localparam int TS_W   = CNT_W + FW,
    localparam int OUT_W  = TS_W + AVG_LOG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N_PH-1:0]  phase_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [OUT_W-1:0] tdc_o,
    output logic             valid_o,
    output logic [FW-1:0]    fine_o,
    output logic             bubble_err_o
);

    // Accumulation counter needs at least one bit even when no averaging.
    localparam int ACW = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam logic [ACW-1:0]  ACC_LAST = ACW'((2 ** AVG_LOG) - 1);
    localparam logic [FW:0]     TWO_N    = (FW + 1)'(2 * N_PH);
    localparam logic [N_PH-2:0] ONE_E    = (N_PH - 1)'(1);

    // Stage 1 capture registers
    logic [N_PH-1:0]  ph_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             v1_q;

    // Stage 2 state and output registers
    logic [OUT_W-1:0] tdc_q,       tdc_d;
    logic             valid_q,     valid_d;
    logic [FW-1:0]    fine_q,      fine_d;
    logic             bub_q,       bub_d;
    logic [TS_W-1:0]  ts_prev_q,   ts_prev_d;
    logic             have_prev_q, have_prev_d;
    logic             mode_prev_q, mode_prev_d;
    logic [OUT_W-1:0] acc_q,       acc_d;
    logic [ACW-1:0]   acc_cnt_q,   acc_cnt_d;

    // Decode results
    logic [FW-1:0]    pop;
    logic [FW:0]      fine_full;
    logic [FW-1:0]    fine;
    logic [N_PH-2:0]  edges;
    logic             illegal;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  diff;
    logic [OUT_W-1:0] acc_sum;
    logic             have_eff;
    logic             mode_chg;

    // Fine decode, bubble check and timestamp formation from the captured phases
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_PH; i++) begin
            pop = pop + FW'(ph_q[i]);
        end
        // Once the MSB phase has flipped we are in the second half-period.
        fine_full = ph_q[N_PH-1] ? (TWO_N - {1'b0, pop}) : {1'b0, pop};
        fine      = fine_full[FW-1:0];
        // A legal thermometer pattern has at most one set bit in its edge map.
        edges     = ph_q[N_PH-1:1] ^ ph_q[N_PH-2:0];
        illegal   = |(edges & (edges - ONE_E));
        ts        = TS_W'(cnt_q) * TS_W'(2 * N_PH) + TS_W'(fine);
        // Modular subtraction absorbs coarse-counter wrap-around.
        diff      = ts - ts_prev_q;
        acc_sum   = acc_q + OUT_W'(diff);
        mode_chg  = (mode_q != mode_prev_q);
        have_eff  = have_prev_q & ~mode_chg;
    end

    // Stage 2 next-state: output selection, difference and accumulation
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        tdc_d       = tdc_q;
        valid_d     = 1'b0;
        fine_d      = fine_q;
        bub_d       = bub_q;
        ts_prev_d   = ts_prev_q;
        have_prev_d = have_prev_q;
        mode_prev_d = mode_prev_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;

        if (v1_q) begin
            fine_d      = fine;
            bub_d       = illegal;
            ts_prev_d   = ts;
            have_prev_d = 1'b1;
            mode_prev_d = mode_q;
            if (!mode_q) begin
                tdc_d   = OUT_W'(ts);
                valid_d = 1'b1;
                if (mode_chg) begin
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end
            end else if (!have_eff) begin
                // First difference sample after a restart: only seed ts_prev.
                acc_d     = '0;
                acc_cnt_d = '0;
            end else if (acc_cnt_q == ACC_LAST) begin
                tdc_d     = acc_sum;
                valid_d   = 1'b1;
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_d     = acc_sum;
                acc_cnt_d = acc_cnt_q + ACW'(1);
            end
        end

        // NOTE: a dropped enable must win over the sample retiring this edge,
        // otherwise the next capture would diff against a stale timestamp.
        if (!en) begin
            have_prev_d = 1'b0;
            acc_d       = '0;
            acc_cnt_d   = '0;
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            ph_q        <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            v1_q        <= 1'b0;
            tdc_q       <= '0;
            valid_q     <= 1'b0;
            fine_q      <= '0;
            bub_q       <= 1'b0;
            ts_prev_q   <= '0;
            have_prev_q <= 1'b0;
            mode_prev_q <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
        end else begin
            if (en) begin
                ph_q   <= phase_i;
                cnt_q  <= count_i;
                mode_q <= mode;
            end
            v1_q        <= en;
            tdc_q       <= tdc_d;
            valid_q     <= valid_d;
            fine_q      <= fine_d;
            bub_q       <= bub_d;
            ts_prev_q   <= ts_prev_d;
            have_prev_q <= have_prev_d;
            mode_prev_q <= mode_prev_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign tdc_o        = tdc_q;
    assign valid_o      = valid_q;
    assign fine_o       = fine_q;
    assign bubble_err_o = bub_q;

endmodule

// File: tb/tb_tdc_core_param.sv
// Scoreboard bench for tdc_core_param: two instances (no averaging and 4x
// averaging) share one stimulus stream; a reference model predicts each
// output strobe with its cycle, and a monitor compares what the DUTs present.
module tb_tdc_core_param;

    localparam int N_PH  = 16;
    localparam int CNT_W = 7;
    localparam int TS_M  = 4096;   // 2^TS_W

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic [N_PH-1:0]   phase_i = '0;
    logic [CNT_W-1:0]  count_i = '0;

    logic [11:0] tdc0;
    logic        valid0, bub0;
    logic [4:0]  fine0;
    logic [13:0] tdc2;
    logic        valid2, bub2;
    logic [4:0]  fine2;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        int tdc;
        int fine;
        bit bub;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    // Reference model state, one slot per instance
    int   avg_n[2] = '{1, 4};
    bit   pend_v[2];
    exp_t pend[2];
    bit   have[2];
    int   prev_ts[2];
    bit   pmode[2];
    int   sum[2];
    int   nacc[2];

    tdc_core_param #(.N_PH(N_PH), .CNT_W(CNT_W), .AVG_LOG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .phase_i(phase_i), .count_i(count_i),
        .tdc_o(tdc0), .valid_o(valid0), .fine_o(fine0), .bubble_err_o(bub0)
    );

    tdc_core_param #(.N_PH(N_PH), .CNT_W(CNT_W), .AVG_LOG(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .phase_i(phase_i), .count_i(count_i),
        .tdc_o(tdc2), .valid_o(valid2), .fine_o(fine2), .bubble_err_o(bub2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input exp_t x);
        if (k == 0) q0.push_back(x);
        else        q2.push_back(x);
    endtask

    // Behavioural model: interprets one cycle of stimulus. A result predicted
    // for a capture retires one cycle later unless reset arrives in between.
    task automatic model_step(input int k, input bit r, input bit e, input bit m,
                              input logic [N_PH-1:0] ph, input logic [CNT_W-1:0] c);
        int   p, fine, ts, d;
        bit   legal;
        exp_t x;
        if (pend_v[k] && r) push(k, pend[k]);
        pend_v[k] = 1'b0;
        if (!r || !e) begin
            have[k] = 1'b0;
            sum[k]  = 0;
            nacc[k] = 0;
            return;
        end
        p    = $countones(ph);
        fine = ph[N_PH-1] ? (2 * N_PH - p) : p;
        ts   = (int'(c) * 2 * N_PH + fine) % TS_M;
        // Legal = a clean thermometer run of ones from either end.
        legal = 1'b0;
        for (int j = 0; j <= N_PH; j++) begin
            logic [N_PH:0] mk;
            mk = (17'd1 << j) - 17'd1;
            if (ph == mk[N_PH-1:0] || ph == ~mk[N_PH-1:0]) legal = 1'b1;
        end
        if (m != pmode[k]) begin
            have[k] = 1'b0;
            sum[k]  = 0;
            nacc[k] = 0;
        end
        x.cyc  = cyc + 2;
        x.fine = fine;
        x.bub  = !legal;
        x.tdc  = 0;
        if (!m) begin
            x.tdc     = ts;
            pend[k]   = x;
            pend_v[k] = 1'b1;
        end else if (have[k]) begin
            d = (ts - prev_ts[k] + TS_M) % TS_M;
            sum[k]  += d;
            nacc[k] += 1;
            if (nacc[k] == avg_n[k]) begin
                x.tdc     = sum[k];
                pend[k]   = x;
                pend_v[k] = 1'b1;
                sum[k]    = 0;
                nacc[k]   = 0;
            end
        end
        prev_ts[k] = ts;
        have[k]    = 1'b1;
        pmode[k]   = m;
    endtask

    // Apply one cycle of stimulus and let the capturing edge pass.
    task automatic drive(input bit r, input bit e, input bit m,
                         input logic [N_PH-1:0] ph, input logic [CNT_W-1:0] c);
        for (int k = 0; k < 2; k++) model_step(k, r, e, m, ph, c);
        rst_n   = r;
        en      = e;
        mode    = m;
        phase_i = ph;
        count_i = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdc0"},   64'(tdc0),   0);
        check({tag, "_valid0"}, 64'(valid0), 0);
        check({tag, "_fine0"},  64'(fine0),  0);
        check({tag, "_bub0"},   64'(bub0),   0);
        check({tag, "_tdc2"},   64'(tdc2),   0);
        check({tag, "_valid2"}, 64'(valid2), 0);
        check({tag, "_fine2"},  64'(fine2),  0);
        check({tag, "_bub2"},   64'(bub2),   0);
    endtask

    // Monitor: every strobe must match the oldest prediction, including its cycle
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("d0_spurious_valid", 64'(valid0), 0);
            end else begin
                exp_t x;
                x = q0.pop_front();
                check("d0_cycle", 64'(cyc),  64'(x.cyc));
                check("d0_tdc",   64'(tdc0), 64'(x.tdc));
                check("d0_fine",  64'(fine0), 64'(x.fine));
                check("d0_bub",   64'(bub0), 64'(x.bub));
            end
        end
        if (valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("d2_spurious_valid", 64'(valid2), 0);
            end else begin
                exp_t x;
                x = q2.pop_front();
                check("d2_cycle", 64'(cyc),  64'(x.cyc));
                check("d2_tdc",   64'(tdc2), 64'(x.tdc));
                check("d2_fine",  64'(fine2), 64'(x.fine));
                check("d2_bub",   64'(bub2), 64'(x.bub));
            end
        end
    end

    initial begin
        logic [CNT_W-1:0] cnt_v;
        bit               m_v;

        // Reset state
        repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_all_zero("reset");

        // Decode in raw mode, coarse count 5, including a bubbled pattern
        drive(1'b1, 1'b1, 1'b0, 16'h0007, 7'd5);
        drive(1'b1, 1'b1, 1'b0, 16'h00FF, 7'd5);
        drive(1'b1, 1'b1, 1'b0, 16'hFF00, 7'd5);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 7'd5);
        drive(1'b1, 1'b1, 1'b0, 16'h00F5, 7'd5);
        drive(1'b1, 1'b1, 1'b0, 16'h003F, 7'd5);

        // Coarse-counter wrap in difference mode: ts 4094 -> 2
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 16'hC000, 7'd127);
        drive(1'b1, 1'b1, 1'b1, 16'h0003, 7'd0);

        // Averaging: ts 0,100,201,300,400 -> diffs 100,101,99,100
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 7'd0);
        drive(1'b1, 1'b1, 1'b1, 16'h000F, 7'd3);
        drive(1'b1, 1'b1, 1'b1, 16'h01FF, 7'd6);
        drive(1'b1, 1'b1, 1'b1, 16'h0FFF, 7'd9);
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 7'd12);

        // Enable gap: capture after the gap only reseeds
        drive(1'b1, 1'b1, 1'b1, 16'h000F, 7'd10);
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h00FF, 7'd12);
        drive(1'b1, 1'b1, 1'b1, 16'h0FFF, 7'd15);

        // Reset mid-operation with a sample in flight and a partial sum
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h0001, 7'd20);
        drive(1'b1, 1'b1, 1'b1, 16'h0003, 7'd22);
        drive(1'b1, 1'b1, 1'b1, 16'h0007, 7'd25);
        drive(1'b0, 1'b1, 1'b1, 16'h000F, 7'd27);
        @(negedge clk);
        check_all_zero("midreset");
        drive(1'b1, 1'b1, 1'b1, 16'h001F, 7'd30);
        drive(1'b1, 1'b1, 1'b1, 16'h003F, 7'd33);
        drive(1'b1, 1'b1, 1'b0, 16'h007F, 7'd35);

        // Randomised traffic: mostly legal patterns, occasional bubbles,
        // enable drops, mode switches and resets
        cnt_v = 7'd0;
        m_v   = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic [N_PH-1:0] ph;
            logic [N_PH:0]   mk;
            bit              r, e;
            if ($urandom_range(0, 9) < 7) begin
                mk = (17'd1 << $urandom_range(0, N_PH)) - 17'd1;
                ph = mk[N_PH-1:0];
                if ($urandom_range(0, 1) == 1) ph = ~ph;
            end else begin
                ph = N_PH'($urandom);
            end
            if ($urandom_range(0, 19) == 0) cnt_v = CNT_W'($urandom);
            else                             cnt_v = cnt_v + CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) m_v = ~m_v;
            r = ($urandom_range(0, 79) != 0);
            e = ($urandom_range(0, 11) != 0);
            drive(r, e, m_v, ph, cnt_v);
        end

        // Drain the pipeline and confirm nothing predicted went missing
        repeat (4) drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("d0_unserved", 64'(q0.size()), 0);
        check("d2_unserved", 64'(q2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
